// File: rtl/versat_alu_pkg.sv
// Shared constants for the Versat ALU: widths, config field positions and
// the function-code map.
package versat_alu_pkg;

  localparam int DATA_W  = 32;
  localparam int N_W     = 5;
  localparam int N_SLOTS = 32;
  localparam int FNS_W   = 4;
  localparam int CONF_W  = 2 * N_W + FNS_W;

  // Most-significant bit of each configdata field
  localparam int SELA_MSB = CONF_W - 1;
  localparam int SELB_MSB = CONF_W - N_W - 1;
  localparam int FNS_MSB  = FNS_W - 1;

  typedef logic [DATA_W-1:0] word_t;

  // Function codes
  localparam logic [FNS_W-1:0] FN_OR          = 4'd0;
  localparam logic [FNS_W-1:0] FN_AND         = 4'd1;
  localparam logic [FNS_W-1:0] FN_MUX         = 4'd2;
  localparam logic [FNS_W-1:0] FN_XOR         = 4'd3;
  localparam logic [FNS_W-1:0] FN_SEXT8       = 4'd4;
  localparam logic [FNS_W-1:0] FN_SEXT16      = 4'd5;
  localparam logic [FNS_W-1:0] FN_SHIFTR_ARTH = 4'd6;
  localparam logic [FNS_W-1:0] FN_SHIFTR_LOG  = 4'd7;
  localparam logic [FNS_W-1:0] FN_CMP_UNS     = 4'd8;
  localparam logic [FNS_W-1:0] FN_CMP_SIG     = 4'd9;
  localparam logic [FNS_W-1:0] FN_ADD         = 4'd10;
  localparam logic [FNS_W-1:0] FN_SUB         = 4'd11;
  localparam logic [FNS_W-1:0] FN_CLZ         = 4'd12;
  localparam logic [FNS_W-1:0] FN_MAX         = 4'd13;
  localparam logic [FNS_W-1:0] FN_MIN         = 4'd14;
  localparam logic [FNS_W-1:0] FN_ABS         = 4'd15;

endpackage

// File: rtl/versat_clz.sv
// Combinational 32-bit leading-zero counter; an all-zero input yields 32.
module versat_clz (
  input  logic [31:0] data,
  output logic [5:0]  count
);

  // Priority encoder: scanning upward, the highest set bit writes last and wins.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (data[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/versat_alu.sv
// Registered 32-bit Versat ALU: selects two operands from the flow bus,
// applies one of 16 functions and registers the result onto flow_out.
module versat_alu
  import versat_alu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SLOTS*DATA_W-1:0]   flow_in,
  input  logic [CONF_W-1:0]           configdata,
  output logic [DATA_W-1:0]           flow_out
);

  logic [N_W-1:0]   sel_a;
  logic [N_W-1:0]   sel_b;
  logic [FNS_W-1:0] fns;

  assign sel_a = configdata[SELA_MSB -: N_W];
  assign sel_b = configdata[SELB_MSB -: N_W];
  assign fns   = configdata[FNS_MSB:0];

  // Slot 0 lives at the most significant end of the bus
  word_t slot [N_SLOTS];

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
    assign slot[gi] = flow_in[(N_SLOTS-gi)*DATA_W-1 -: DATA_W];
  end

  word_t opa;
  word_t opb;

  // Operand muxes; a selector that matches no slot leaves the operand at zero
  always_comb begin
    opa = '0;
    opb = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (sel_a == k[N_W-1:0]) opa = slot[k];
      if (sel_b == k[N_W-1:0]) opb = slot[k];
    end
  end

  logic [5:0] clz_count;

  versat_clz u_clz (
    .data  (opa),
    .count (clz_count)
  );

  word_t diff;
  logic  lt_uns;
  logic  lt_sig;

  assign diff   = opb - opa;
  assign lt_uns = opb < opa;
  assign lt_sig = $signed(opb) < $signed(opa);

  word_t result_next;

  // Function select; the compare flavours share the opb - opa subtractor
  always_comb begin
    result_next = '0;
    case (fns)
      FN_OR:          result_next = opa | opb;
      FN_AND:         result_next = opa & opb;
      FN_MUX:         result_next = opa[31] ? '0 : opb;
      FN_XOR:         result_next = opa ^ opb;
      FN_SEXT8:       result_next = {{24{opa[7]}}, opa[7:0]};
      FN_SEXT16:      result_next = {{16{opa[15]}}, opa[15:0]};
      FN_SHIFTR_ARTH: result_next = {opa[31], opa[31:1]};
      FN_SHIFTR_LOG:  result_next = {1'b0, opa[31:1]};
      FN_CMP_UNS:     result_next = {lt_uns, diff[30:0]};
      FN_CMP_SIG:     result_next = {lt_sig, diff[30:0]};
      FN_ADD:         result_next = opa + opb;
      FN_SUB:         result_next = diff;
      FN_CLZ:         result_next = {26'd0, clz_count};
      // Ties fall through to opb for both MAX and MIN
      FN_MAX:         result_next = lt_sig ? opa : opb;
      FN_MIN:         result_next = (!lt_sig && opa != opb) ? opa : opb;
      FN_ABS:         result_next = opa[31] ? (~opa + 32'd1) : opa;
      default:        result_next = '0;
    endcase
  end

  word_t flow_out_reg;

  // Output register; reset discards the cycle's result
  always_ff @(posedge clk) begin
    if (rst) flow_out_reg <= '0;
    else     flow_out_reg <= result_next;
  end

  assign flow_out = flow_out_reg;

endmodule

// File: tb/tb_versat_alu.sv
// Self-checking bench for versat_alu: reset, function sweep, vector table,
// selection sequences and randomized traffic against a behavioural model.
module tb_versat_alu;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1023:0] flow_in = '0;
  logic [13:0]   configdata = '0;
  logic [31:0]   flow_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] slot_val [32];

  versat_alu dut (
    .clk        (clk),
    .rst        (rst),
    .flow_in    (flow_in),
    .configdata (configdata),
    .flow_out   (flow_out)
  );

  always #5 clk = ~clk;

  task automatic set_slot(input int k, input logic [31:0] v);
    slot_val[k] = v;
    flow_in[(32-k)*32-1 -: 32] = v;
  endtask

  task automatic set_cfg(input int sa, input int sb, input int f);
    configdata = {5'(sa), 5'(sb), 4'(f)};
  endtask

  // Advance one clock edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Behavioural reference written from the function definitions
  function automatic logic [31:0] model(input int f, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      ua;
    longint      ub;
    int          t;
    logic [31:0] d;
    int          n;
    sa = a;
    sb = b;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    d  = b - a;
    case (f)
      0:  return a | b;
      1:  return a & b;
      2:  return (sa < 0) ? 32'd0 : b;
      3:  return a ^ b;
      4:  begin t = sa <<< 24; return t >>> 24; end
      5:  begin t = sa <<< 16; return t >>> 16; end
      6:  return sa >>> 1;
      7:  return a >> 1;
      8:  return {(ub < ua) ? 1'b1 : 1'b0, d[30:0]};
      9:  return {(sb < sa) ? 1'b1 : 1'b0, d[30:0]};
      10: return 32'(ua + ub);
      11: return 32'(ub - ua);
      12: begin
            n = 0;
            while (n < 32 && a[31-n] == 1'b0) n++;
            return 32'(n);
          end
      13: return (sa > sb) ? a : b;
      14: return (sa < sb) ? a : b;
      default: return (sa < 0) ? 32'(0 - sa) : a;
    endcase
  endfunction

  typedef struct {
    int          fns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    v.fns = f; v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  initial begin
    logic [31:0] sweep_exp [16];
    logic [31:0] prev;
    logic [31:0] exp;
    int          sa, sb, f;
    string       nm;

    for (int k = 0; k < 32; k++) set_slot(k, 32'(k * 3 + 1));

    tbl.push_back(mk(4,  32'h00000080, 32'h0,        32'hFFFFFF80));
    tbl.push_back(mk(5,  32'hFFFF8000, 32'h0,        32'hFFFF8000));
    tbl.push_back(mk(6,  32'hFFFF8000, 32'h0,        32'hFFFFC000));
    tbl.push_back(mk(7,  32'hFFFF8000, 32'h0,        32'h7FFFC000));
    tbl.push_back(mk(15, 32'hFFFFFFFB, 32'h0,        32'h00000005));
    tbl.push_back(mk(2,  32'hFFFFFFFB, 32'h00000007, 32'h00000000));
    tbl.push_back(mk(9,  32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFE));
    tbl.push_back(mk(8,  32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFE));
    tbl.push_back(mk(13, 32'h00000001, 32'hFFFFFFFF, 32'h00000001));
    tbl.push_back(mk(14, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF));
    tbl.push_back(mk(12, 32'h00000000, 32'h0,        32'd32));
    tbl.push_back(mk(12, 32'h80000000, 32'h0,        32'd0));
    tbl.push_back(mk(12, 32'h00000001, 32'h0,        32'd31));
    tbl.push_back(mk(15, 32'h80000000, 32'h0,        32'h80000000));
    tbl.push_back(mk(13, 32'h00000009, 32'h00000009, 32'h00000009));
    tbl.push_back(mk(14, 32'hFFFFFFF0, 32'h00000003, 32'hFFFFFFF0));
    tbl.push_back(mk(2,  32'h7FFFFFFF, 32'h0000ABCD, 32'h0000ABCD));

    // Reset with live inputs holds the output at zero
    set_cfg(0, 1, 10);
    step();
    check("reset_hold", flow_out, 32'd0);
    rst = 1'b0;
    #1;
    check("reset_release_pre_edge", flow_out, 32'd0);
    step();
    check("first_after_reset", flow_out, 32'd1 + 32'd4);

    // Sweep: opa=25, opb=26, one function per cycle, result one edge later
    sweep_exp = '{27, 24, 26, 3, 25, 25, 12, 12, 1, 1, 51, 1, 27, 26, 25, 25};
    set_slot(0, 32'd25);
    set_slot(1, 32'd26);
    set_cfg(0, 1, 0);
    step();
    prev = flow_out;
    check("sweep_fn0", flow_out, sweep_exp[0]);
    for (int i = 1; i < 16; i++) begin
      set_cfg(0, 1, i);
      #1;
      check($sformatf("sweep_hold_fn%0d", i), flow_out, prev);
      step();
      check($sformatf("sweep_fn%0d", i), flow_out, sweep_exp[i]);
      prev = flow_out;
    end

    // Vector table of sign and boundary cases
    foreach (tbl[i]) begin
      set_slot(0, tbl[i].a);
      set_slot(1, tbl[i].b);
      set_cfg(0, 1, tbl[i].fns);
      step();
      check($sformatf("vec%0d_fn%0d", i, tbl[i].fns), flow_out, tbl[i].exp);
    end

    // Selection: slot 3 = 10, slot 7 = 4
    set_slot(3, 32'd10);
    set_slot(7, 32'd4);
    set_cfg(7, 3, 10);
    step();
    check("sel_add", flow_out, 32'd14);
    set_cfg(7, 3, 11);
    step();
    check("sel_sub", flow_out, 32'd6);
    set_slot(31, 32'd100);
    set_cfg(7, 3, 10);
    step();
    check("sel_before_change", flow_out, 32'd14);
    set_cfg(31, 3, 10);
    #1;
    check("sel_change_hold", flow_out, 32'd14);
    step();
    check("sel_change_lsb_slot", flow_out, 32'd110);

    // Mid-stream reset discards the result and resumes one edge after release
    rst = 1'b1;
    set_cfg(7, 3, 3);
    step();
    check("midreset_zero", flow_out, 32'd0);
    rst = 1'b0;
    step();
    check("midreset_resume", flow_out, 32'd4 ^ 32'd10);

    // Randomized traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < 32; k++) begin
        case ($urandom_range(0, 7))
          0:       set_slot(k, 32'h00000000);
          1:       set_slot(k, 32'h80000000);
          2:       set_slot(k, 32'hFFFFFFFF);
          3:       set_slot(k, 32'($urandom_range(0, 255)));
          default: set_slot(k, $urandom);
        endcase
      end
      sa = $urandom_range(0, 31);
      sb = $urandom_range(0, 31);
      f  = $urandom_range(0, 15);
      set_cfg(sa, sb, f);
      exp = model(f, slot_val[sa], slot_val[sb]);
      step();
      nm = $sformatf("rand%0d_fn%0d_a%0d_b%0d", i, f, sa, sb);
      check(nm, flow_out, exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/versat_alu.md
Name: versat_alu

Overview:
- Registered 32-bit integer ALU for a Versat functional-unit array.
- Picks two operands (A, B) from a wide flow bus of data slots using config selectors.
- Computes one of 16 functions and registers the result onto its own output slot.
- Pure datapath: no handshake. Config is static while the unit runs.

Parameters:
- DATA_W, 32: operand/result width. Function semantics below assume 32.
- N_W, 5: width of each operand selector.
- N_SLOTS, 32: number of DATA_W slots on the flow bus (at most 2^N_W).
- FNS_W, 4: function code width.
- CONF_W, 2*N_W+FNS_W (14): configuration word width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flow_in  in  N_SLOTS*DATA_W  data bus. Slot k = flow_in[(N_SLOTS-k)*DATA_W-1 -: DATA_W], so slot 0 is the most significant.
- configdata  in  CONF_W  [CONF_W-1 -: N_W] = selA; [CONF_W-N_W-1 -: N_W] = selB; [FNS_W-1:0] = fns.
- flow_out  out  DATA_W  registered ALU result.

Behaviour:
- opa = slot[selA], opb = slot[selB], combinational. A selector >= N_SLOTS yields operand 0.
- Latency is 1 cycle. flow_out at edge n+1 = f(fns, opa, opb) sampled at edge n. There is no enable; the unit computes every cycle.
- rst at an edge sets flow_out = 0, overriding the computation. Reset mid-stream discards that cycle's result. The first result after rst deasserts appears one edge later.
- Function codes (fns):
  - 0 OR: opa | opb.
  - 1 AND: opa & opb.
  - 2 MUX: opa[31] ? 0 : opb.
  - 3 XOR: opa ^ opb.
  - 4 SEXT8: {{24{opa[7]}}, opa[7:0]}.
  - 5 SEXT16: {{16{opa[15]}}, opa[15:0]}.
  - 6 SHIFTR_ARTH: {opa[31], opa[31:1]}.
  - 7 SHIFTR_LOG: {1'b0, opa[31:1]}.
  - 8 CMP_UNS: bits[30:0] = (opb - opa)[30:0]; bit31 = (opb < opa) unsigned.
  - 9 CMP_SIG: bits[30:0] = (opb - opa)[30:0]; bit31 = (opb < opa) signed.
  - 10 ADD: opa + opb, mod 2^32, no carry out.
  - 11 SUB: opb - opa, mod 2^32.
  - 12 CLZ: leading-zero count of opa, 0..32, zero-extended. opa = 0 gives 32.
  - 13 MAX: signed maximum. When opa == opb, return opb.
  - 14 MIN: signed minimum. When opa == opb, return opb.
  - 15 ABS: opa[31] ? -opa : opa. 0x80000000 returns 0x80000000.
- No flags or overflow outputs.
- Changing fns or the selectors takes effect on the next edge.

Decomposition:
- Package versat_alu_pkg holds:
  - localparams for the 16 function codes, in the order above;
  - DATA_W, N_W, FNS_W, and the config field offsets.
- One sub-module, versat_clz: combinational 32-bit leading-zero counter with a 6-bit output. Implement it as a priority encoder or log-tree.
- Operand mux and function case stay in the top module.

Test Plan:
- Reset: hold rst for 1 edge with any input -> flow_out = 0. Deassert rst -> first result appears after one edge.
- Sweep, opa=25, opb=26, fns 0..15, one per cycle. Each result must appear 1 cycle later:
  - 0..3: OR 27, AND 24, MUX 26, XOR 3;
  - 4..7: SEXT8 25, SEXT16 25, SRA 12, SRL 12;
  - 8..11: CMP_UNS 1, CMP_SIG 1, ADD 51, SUB 1;
  - 12..15: CLZ 27, MAX 26, MIN 25, ABS 25.
- Sign cases:
  - opa=0x00000080: SEXT8 -> 0xFFFFFF80.
  - opa=0xFFFF8000: SEXT16 -> 0xFFFF8000, SRA -> 0xFFFFC000, SRL -> 0x7FFFC000.
  - opa=0xFFFFFFFB: ABS -> 5, MUX (opb=7) -> 0.
- Compare/minmax with opa=1, opb=0xFFFFFFFF:
  - CMP_SIG -> 0xFFFFFFFE;
  - CMP_UNS -> 0x7FFFFFFE;
  - MAX -> 1;
  - MIN -> 0xFFFFFFFF.
- CLZ edges: opa=0 -> 32; 0x80000000 -> 0; 1 -> 31. ABS of 0x80000000 -> 0x80000000.
- Selection: slot 3=10, slot 7=4, selA=7, selB=3, ADD -> 14, SUB -> 6. selA=31 picks the least-significant slot. Change selA mid-run -> the new operand is reflected next cycle.
